set_candidate_collector: RTL and testbench

- Receiving end of the row-scan interface that the SET controller drives toward the map cells.
- Collects per-row, per-circle hit masks for circles A, B and C, combines them according to the latched mode, and popcounts each combined row.
- Accumulates the row counts over the 8x8 grid and reports the final candidate count with a one-cycle valid pulse.
- Sits between the MapCell row outputs and the top-level result port.

---
 rtl/set_candidate_collector.sv | 163 ++++++++++++++++
 tb/tb_set_candidate_collector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/set_candidate_collector.sv
// Collects per-row A/B/C hit masks from the row-scan interface, combines them per the
// latched mode, and accumulates per-row popcounts into a final candidate count.
module set_candidate_collector #(
  parameter int N_ROWS = 8,
  parameter int ROW_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             row_en,
  input  logic [2:0]       row_id,
  input  logic [1:0]       circ_sel,
  input  logic             row_last,
  input  logic [ROW_W-1:0] hit,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] candidate,
  output logic             proto_err
);

  localparam int PC_W = $clog2(ROW_W + 1);
  localparam logic [2:0] LAST_ROW = 3'(N_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ACCUM, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_mode;
  logic [ROW_W-1:0]   r_mask_a, r_mask_b, r_mask_c, r_row_mask;
  logic [2:0]         r_wr;
  logic               r_pend;
  logic [CNT_W-1:0]   r_total, r_cand;
  logic [2:0]         r_exp_row;
  logic               r_busy, r_valid, r_err;

  logic               w_beat;
  logic [2:0]         w_in, w_wr, w_req;
  logic [ROW_W-1:0]   w_a, w_b, w_c, w_comb;
  logic               w_missing;
  logic [PC_W-1:0]    w_pc;
  logic [CNT_W-1:0]   w_add;

  assign w_beat = row_en && !start && (r_state == S_COLLECT);

  // This beat's hit is bypassed in so a row_last beat can carry its own circle's data.
  always_comb begin
    w_in = 3'b000;
    if (w_beat && circ_sel != 2'd3) w_in[circ_sel] = 1'b1;
    w_wr = r_wr | w_in;
    case (r_mode)
      2'd0:    w_req = 3'b001;
      2'd3:    w_req = 3'b111;
      default: w_req = 3'b011;
    endcase
    w_missing = |(w_req & ~w_wr);
    w_a = w_wr[0] ? (w_in[0] ? hit : r_mask_a) : '0;
    w_b = w_wr[1] ? (w_in[1] ? hit : r_mask_b) : '0;
    w_c = w_wr[2] ? (w_in[2] ? hit : r_mask_c) : '0;
    case (r_mode)
      2'd0:    w_comb = w_a;
      2'd1:    w_comb = w_a & w_b;
      2'd2:    w_comb = w_a ^ w_b;
      default: w_comb = ((w_a & w_b) | (w_b & w_c) | (w_c & w_a)) & ~(w_a & w_b & w_c);
    endcase
  end

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < ROW_W; i++) w_pc = w_pc + PC_W'(r_row_mask[i]);
    w_add = r_pend ? CNT_W'(w_pc) : '0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_COLLECT;
      S_COLLECT: if (start) w_state_next = S_COLLECT;
                 else if (w_beat && row_last && r_exp_row == LAST_ROW) w_state_next = S_ACCUM;
      S_ACCUM:   w_state_next = start ? S_COLLECT : S_DONE;
      default:   w_state_next = start ? S_COLLECT : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= '0;
      r_mask_a   <= '0;
      r_mask_b   <= '0;
      r_mask_c   <= '0;
      r_row_mask <= '0;
      r_wr       <= '0;
      r_pend     <= 1'b0;
      r_total    <= '0;
      r_cand     <= '0;
      r_exp_row  <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else if (start) begin
      r_mode     <= mode;
      r_mask_a   <= '0;
      r_mask_b   <= '0;
      r_mask_c   <= '0;
      r_row_mask <= '0;
      r_wr       <= '0;
      r_pend     <= 1'b0;
      r_total    <= '0;
      r_cand     <= '0;
      r_exp_row  <= '0;
      r_busy     <= 1'b1;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          r_total <= r_total + w_add;
          r_pend  <= 1'b0;
          if (w_beat) begin
            if (circ_sel == 2'd3 || row_id != r_exp_row) r_err <= 1'b1;
            if (w_in[0]) r_mask_a <= hit;
            if (w_in[1]) r_mask_b <= hit;
            if (w_in[2]) r_mask_c <= hit;
            r_wr <= w_wr;
            if (row_last) begin
              r_row_mask <= w_comb;
              r_mask_a   <= '0;
              r_mask_b   <= '0;
              r_mask_c   <= '0;
              r_wr       <= '0;
              r_pend     <= 1'b1;
              r_exp_row  <= r_exp_row + 3'd1;
              if (w_missing) r_err <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          r_cand  <= r_total + w_add;
          r_pend  <= 1'b0;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          if (row_en) r_err <= 1'b1;
        end
        S_DONE: begin
          if (row_en) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign candidate = r_cand;
  assign proto_err = r_err;

endmodule

// File: tb/tb_set_candidate_collector.sv
// Scoreboard bench for set_candidate_collector: each scan pushes its expected result,
// and a negedge monitor pops and compares whenever valid pulses.
module tb_set_candidate_collector;

  logic       clk = 1'b0;
  logic       rst, start, row_en, row_last;
  logic [1:0] mode, circ_sel;
  logic [2:0] row_id;
  logic [7:0] hit;
  logic       busy, valid, proto_err;
  logic [7:0] candidate;

  typedef struct {int cand; int err;} exp_t;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  set_candidate_collector dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .row_en(row_en),
    .row_id(row_id), .circ_sel(circ_sel), .row_last(row_last), .hit(hit),
    .busy(busy), .valid(valid), .candidate(candidate), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_candidate", int'(candidate), e.cand);
        chk("sb_proto_err", int'(proto_err), e.err);
      end
    end
  end

  task automatic start_scan(input int m);
    start = 1'b1; mode = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input int id, input int sel, input bit last, input logic [7:0] h);
    row_en = 1'b1; row_id = 3'(id); circ_sel = 2'(sel); row_last = last; hit = h;
    @(posedge clk); #1;
    row_en = 1'b0; row_last = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n0;
    n0 = n_valid;
    for (int i = 0; i < 30 && n_valid == n0; i++) @(posedge clk);
    #1;
    chk(tag, n_valid - n0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; row_en = 1'b0; row_last = 1'b0;
    row_id = '0; circ_sel = '0; hit = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_candidate", candidate, 0);
    chk("rst_proto_err", proto_err, 0);
    rst = 1'b0;

    // Mode 0, all rows full; mode port scrambled mid-scan must not matter.
    start_scan(0);
    mode = 2'd3;
    sb.push_back('{cand: 64, err: 0});
    for (int r = 0; r < 8; r++) beat(r, 0, 1'b1, 8'hFF);
    chk("t1_accum_valid_low", valid, 0);
    chk("t1_accum_busy", busy, 1);
    @(posedge clk); #1;
    chk("t1_valid_high", valid, 1);
    chk("t1_busy_low", busy, 0);
    @(posedge clk); #1;
    chk("t1_valid_pulse_end", valid, 0);
    chk("t1_n_valid", n_valid, 1);

    // Mode 2 XOR: F0 ^ 3C = CC, 4 bits per row.
    start_scan(2);
    sb.push_back('{cand: 32, err: 0});
    for (int r = 0; r < 8; r++) begin
      beat(r, 0, 1'b0, 8'hF0);
      beat(r, 1, 1'b1, 8'h3C);
    end
    wait_valid("t2_valid");

    // Mode 3 exactly-two-of-three: 3C per row, back-to-back beats.
    start_scan(3);
    sb.push_back('{cand: 32, err: 0});
    for (int r = 0; r < 8; r++) begin
      beat(r, 0, 1'b0, 8'hFF);
      beat(r, 1, 1'b0, 8'h0F);
      beat(r, 2, 1'b1, 8'h33);
    end
    wait_valid("t3_valid");

    // Mode 1 with row 3 missing A: that row counts zero.
    start_scan(1);
    sb.push_back('{cand: 28, err: 1});
    for (int r = 0; r < 8; r++) begin
      if (r != 3) beat(r, 0, 1'b0, 8'hFF);
      beat(r, 1, 1'b1, 8'h0F);
      if (r == 3) chk("t4a_err_live", proto_err, 1);
    end
    wait_valid("t4a_valid");

    // Row id sequence skips 2; scan still completes after 8 rows.
    start_scan(0);
    chk("t4b_err_cleared", proto_err, 0);
    sb.push_back('{cand: 24, err: 1});
    for (int r = 0; r < 8; r++) beat((r < 2) ? r : r + 1, 0, 1'b1, 8'h07);
    wait_valid("t4b_valid");

    // Restart at row 4; the beat coinciding with start is discarded.
    start_scan(0);
    for (int r = 0; r < 4; r++) beat(r, 0, 1'b1, 8'hFF);
    start = 1'b1; mode = 2'd0;
    beat(0, 0, 1'b1, 8'hFF);
    start = 1'b0;
    chk("t5a_cand_cleared", candidate, 0);
    chk("t5a_busy", busy, 1);
    sb.push_back('{cand: 8, err: 0});
    for (int r = 0; r < 8; r++) beat(r, 0, 1'b1, 8'h01);
    wait_valid("t5a_valid");

    // Reset mid-scan: no valid, all outputs cleared.
    start_scan(0);
    beat(0, 3, 1'b0, 8'hFF);
    for (int r = 0; r < 5; r++) beat(r, 0, 1'b1, 8'hFF);
    chk("t5b_err_before_rst", proto_err, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5b_busy", busy, 0);
    chk("t5b_valid", valid, 0);
    chk("t5b_candidate", candidate, 0);
    chk("t5b_proto_err", proto_err, 0);
    repeat (6) @(posedge clk);
    #1;

    // IDLE beats are ignored silently.
    beat(5, 3, 1'b1, 8'hFF);
    beat(2, 0, 1'b1, 8'hFF);
    chk("t6_idle_err", proto_err, 0);
    chk("t6_idle_cand", candidate, 0);
    chk("t6_idle_busy", busy, 0);

    // A beat during ACCUM flags an error but does not change the count.
    start_scan(0);
    sb.push_back('{cand: 16, err: 1});
    for (int r = 0; r < 8; r++) beat(r, 0, 1'b1, 8'h81);
    beat(0, 0, 1'b1, 8'hFF);
    wait_valid("t6_valid");
    repeat (2) @(posedge clk); #1;
    chk("t6_cand_hold", candidate, 16);
    chk("t6_err_sticky", proto_err, 1);
    beat(1, 0, 1'b1, 8'hFF);
    chk("t6_cand_after_idle_beat", candidate, 16);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
